// File: rtl/tdm_pkg.sv
// Shared TDM constants and types for the mux/demux pair.
// Keeps the slot geometry and FSM encoding in one place for both link ends.
package tdm_pkg;

  localparam int SLOT_W    = 2;
  localparam int NUM_SLOTS = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input slot_t s);
    logic [NUM_SLOTS-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Link-side and channel-side signals of the 1-to-4 TDM demultiplexer.
// The slave modport is the demux; the master modport is whoever feeds and observes it.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] Din;
  logic             Din_valid;
  logic             Frame_sync;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             Sel1;
  logic             Sel2;
  logic             Locked;
  logic             Frame_done;
  logic             Sync_err;

  modport master (
    output Din, Din_valid, Frame_sync,
    input  A, B, C, D, Sel1, Sel2, Locked, Frame_done, Sync_err
  );

  modport slave (
    input  Din, Din_valid, Frame_sync,
    output A, B, C, D, Sel1, Sel2, Locked, Frame_done, Sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: tracks the next expected slot and emits the one-hot
// staging write enable for the word accepted this cycle.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 load1_i,
  input  logic                 inc_i,
  output slot_t                slot_o,
  output logic [NUM_SLOTS-1:0] we_o
);

  slot_t slot_q;
  slot_t slot_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d = slot_q;
    we_o   = '0;
    if (clear_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = slot_t'(1);
      we_o   = slot_onehot('0);
    end else if (inc_i) begin
      slot_d = slot_q + slot_t'(1);
      we_o   = slot_onehot(slot_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 1-to-4 TDM demultiplexer: stages slot words and publishes A..D once per full frame.
// Build option: define TDM_DEMUX_MISSING_SYNC_CHECK_EN to drop lock when slot 0 arrives without sync.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  tdm_demux4_if.slave  bus
);

  tdm_state_e           state_q;
  slot_t                slot;
  logic [NUM_SLOTS-1:0] we;
  logic                 clear;
  logic                 load1;
  logic                 inc;
  logic                 misalign;
  logic                 miss_sync;
  logic [WIDTH-1:0]     stage_q [NUM_SLOTS];
  logic [WIDTH-1:0]     out_q   [NUM_SLOTS];
  logic                 frame_pend_q;
  logic                 frame_done_q;
  logic                 sync_err_q;

  always_comb begin
    clear     = 1'b0;
    load1     = 1'b0;
    inc       = 1'b0;
    misalign  = 1'b0;
    miss_sync = 1'b0;
    if (bus.Din_valid) begin
      if (bus.Frame_sync) begin
        load1    = 1'b1;
        misalign = (state_q == LOCKED) && (slot != '0);
      end else if (state_q == LOCKED) begin
`ifdef TDM_DEMUX_MISSING_SYNC_CHECK_EN
        if (slot == '0) begin
          clear     = 1'b1;
          miss_sync = 1'b1;
        end else begin
          inc = 1'b1;
        end
`else
        inc = 1'b1;
`endif
      end
    end
  end

  tdm_slot_counter u_slot_counter (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .clear_i (clear),
    .load1_i (load1),
    .inc_i   (inc),
    .slot_o  (slot),
    .we_o    (we)
  );

  // NOTE: staging and output words are reset explicitly because a reset mid-frame must visibly zero A..D.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= HUNT;
      frame_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stage_q[i] <= '0;
        out_q[i]   <= '0;
      end
    end else begin
      frame_pend_q <= we[NUM_SLOTS-1];
      frame_done_q <= frame_pend_q;
      sync_err_q   <= misalign | miss_sync;
      if (load1) begin
        state_q <= LOCKED;
      end else if (clear) begin
        state_q <= HUNT;
      end
      // Publish one edge after slot 3 lands; a concurrent slot-0 write only touches staging.
      if (frame_pend_q) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          out_q[i] <= stage_q[i];
        end
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (misalign && (i != 0)) begin
          stage_q[i] <= '0;
        end else if (we[i]) begin
          stage_q[i] <= bus.Din;
        end
      end
    end
  end

  assign bus.A          = out_q[0];
  assign bus.B          = out_q[1];
  assign bus.C          = out_q[2];
  assign bus.D          = out_q[3];
  assign bus.Sel1       = slot[1];
  assign bus.Sel2       = slot[0];
  assign bus.Locked     = (state_q == LOCKED);
  assign bus.Frame_done = frame_done_q;
  assign bus.Sync_err   = sync_err_q;

endmodule
